// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 interrupt/trap controller:
// register indices, Status frame bit positions and exception codes.
package cp0_pkg;

    // CP0 register indices
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // One Status frame is FRAME_W bits; the interrupt mask starts at IM_LSB
    localparam int FRAME_W = 5;
    localparam int IM_LSB  = 16;

    // Bit positions inside a Status frame
    localparam int BIT_IE     = 0;
    localparam int BIT_SYS_EN = 1;
    localparam int BIT_BRK_EN = 2;
    localparam int BIT_TEQ_EN = 3;
    localparam int BIT_IRQ_EN = 4;

    // Exception codes shared with the decoder
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    localparam logic [31:0] STATUS_RST = 32'h0000_000F;

    // Which single action owns the state update this cycle
    typedef enum logic [1:0] {
        CP0_IDLE,
        CP0_ERET,
        CP0_TRAP,
        CP0_WRITE
    } cp0_op_e;

    // Exception accepted only when globally enabled and its own enable is set;
    // unknown codes are never accepted.
    function automatic logic exc_enabled(input logic [BIT_TEQ_EN:0] frame,
                                         input logic [4:0]          code);
        logic en;
        case (code)
            EXC_SYSCALL: en = frame[BIT_SYS_EN];
            EXC_BREAK:   en = frame[BIT_BRK_EN];
            EXC_TEQ:     en = frame[BIT_TEQ_EN];
            default:     en = 1'b0;
        endcase
        return frame[BIT_IE] & en;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous level interrupt lines.
module irq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    // Shift each line through STAGES flops; stage[STAGES-1] is the safe copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/cp0_irq_ctrl.sv
// Coprocessor-0: trap/return handling with a nested Status frame stack,
// synchronised external interrupts and a Count/Compare timer interrupt.
module cp0_irq_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ     = 6,
    parameter int          NEST_DEPTH  = 3,
    parameter logic [31:0] VECTOR      = 32'h0040_0004,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mtc0,
    input  logic [4:0]         waddr,
    input  logic [31:0]        wdata,
    input  logic [4:0]         raddr,
    output logic [31:0]        rdata,
    input  logic [31:0]        pc,
    input  logic               exception,
    input  logic [4:0]         cause,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        status,
    output logic [31:0]        epc,
    output logic               trap,
    output logic [31:0]        trap_addr,
    output logic [1:0]         depth
);

    localparam int          STACK_W     = FRAME_W * NEST_DEPTH;
    localparam int          IP_W        = NUM_IRQ + 1;
    localparam logic [15:0] STACK_MASK  = 16'((32'd1 << STACK_W) - 32'd1);
    localparam logic [31:0] STATUS_WMSK = {16'hFFFF, STACK_MASK};
    localparam logic [1:0]  DEPTH_MAX   = 2'(NEST_DEPTH);

    logic [31:0]        status_q;
    logic [31:0]        count_q;
    logic [31:0]        compare_q;
    logic [31:0]        epc_q;
    logic [4:0]         exccode_q;
    logic               timer_ip_q;
    logic [1:0]         depth_q;

    logic [NUM_IRQ-1:0] irq_s;
    logic [IP_W-1:0]    ip;
    logic [IP_W-1:0]    im;
    logic [FRAME_W-1:0] live;
    logic               exc_ok;
    logic               irq_ok;
    logic               timer_hit;
    logic [15:0]        stack_push;
    logic [15:0]        stack_pop;
    cp0_op_e            op;

    irq_sync #(
        .WIDTH  (NUM_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq),
        .q     (irq_s)
    );

    assign live      = status_q[FRAME_W-1:0];
    assign ip        = {timer_ip_q, irq_s};
    assign im        = status_q[IM_LSB +: IP_W];
    assign timer_hit = (count_q == compare_q) && (compare_q != 32'd0);

    assign exc_ok = exception & exc_enabled(live[BIT_TEQ_EN:0], cause);
    assign irq_ok = live[BIT_IE] & live[BIT_IRQ_EN] & (|(ip & im))
                  & (depth_q < DEPTH_MAX);

    // Pushing drops whatever frame falls off the top; popping zero-fills it
    assign stack_push = (status_q[15:0] << FRAME_W) & STACK_MASK;
    assign stack_pop  = (status_q[15:0] & STACK_MASK) >> FRAME_W;

    // Pick the single winner: eret, then trap, then a register write
    always_comb begin
        op = CP0_IDLE;
        if (eret) begin
            op = CP0_ERET;
        end else if (exc_ok || irq_ok) begin
            op = CP0_TRAP;
        end else if (mtc0) begin
            op = CP0_WRITE;
        end
    end

    // Trap is masked while reset is held so the PC mux sees a clean pc
    assign trap      = rst_n & (op == CP0_TRAP);
    assign trap_addr = trap ? VECTOR : pc;

    // Architectural state update; Count and the timer flag run every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= STATUS_RST;
            count_q    <= '0;
            compare_q  <= '0;
            epc_q      <= '0;
            exccode_q  <= '0;
            timer_ip_q <= 1'b0;
            depth_q    <= '0;
        end else begin
            count_q <= count_q + 32'd1;
            if (timer_hit) begin
                timer_ip_q <= 1'b1;
            end
            unique case (op)
                CP0_ERET: begin
                    if (depth_q != 2'd0) begin
                        status_q <= {status_q[31:16], stack_pop};
                        depth_q  <= depth_q - 2'd1;
                    end
                end
                CP0_TRAP: begin
                    status_q <= {status_q[31:16], stack_push};
                    if (depth_q < DEPTH_MAX) begin
                        depth_q <= depth_q + 2'd1;
                    end
                    exccode_q <= exc_ok ? cause : 5'd0;
                    epc_q     <= exc_ok ? (pc - 32'd4) : pc;
                end
                CP0_WRITE: begin
                    case (waddr)
                        REG_STATUS:  status_q <= wdata & STATUS_WMSK;
                        REG_COUNT:   count_q  <= wdata;
                        REG_COMPARE: begin
                            compare_q  <= wdata;
                            timer_ip_q <= 1'b0;
                        end
                        REG_EPC:     epc_q    <= wdata;
                        default:     ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Read port shows pre-edge state; unimplemented indices read as zero
    always_comb begin
        rdata = '0;
        case (raddr)
            REG_STATUS:  rdata = status_q;
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_EPC:     rdata = epc_q;
            REG_CAUSE: begin
                rdata[6:2]            = exccode_q;
                rdata[IM_LSB +: IP_W] = ip;
            end
            default:     rdata = '0;
        endcase
    end

    assign status = status_q;
    assign epc    = epc_q;
    assign depth  = depth_q;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: a vector table for single-cycle behaviour
// plus hand sequences for interrupt latency, timer, nesting and async reset.
module tb_cp0_irq_ctrl;
    import cp0_pkg::*;

    localparam int          NUM_IRQ   = 6;
    localparam int          SYNC      = 2;
    localparam logic [31:0] VEC       = 32'h0040_0004;
    localparam int          TIMER_BIT = 16 + NUM_IRQ;
    localparam int          NVEC      = 14;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mtc0 = 1'b0;
    logic [4:0]         waddr = '0;
    logic [31:0]        wdata = '0;
    logic [4:0]         raddr = '0;
    logic [31:0]        rdata;
    logic [31:0]        pc = '0;
    logic               exception = 1'b0;
    logic [4:0]         cause = '0;
    logic               eret = 1'b0;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [31:0]        status;
    logic [31:0]        epc;
    logic               trap;
    logic [31:0]        trap_addr;
    logic [1:0]         depth;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_irq_ctrl #(
        .NUM_IRQ     (NUM_IRQ),
        .NEST_DEPTH  (3),
        .VECTOR      (VEC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mtc0      (mtc0),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .pc        (pc),
        .exception (exception),
        .cause     (cause),
        .eret      (eret),
        .irq       (irq),
        .status    (status),
        .epc       (epc),
        .trap      (trap),
        .trap_addr (trap_addr),
        .depth     (depth)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mtc0;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  cause;
        logic        eret;
        logic        exp_trap;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_depth;
    } vec_t;

    vec_t vecs[NVEC];

    logic [31:0] push_exp[4];
    logic [31:0] live_w[3];
    logic [31:0] pop_exp[3];
    logic [1:0]  push_depth[4];
    logic [1:0]  pop_depth[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        mtc0 = 1'b0; waddr = '0; wdata = '0;
        exception = 1'b0; cause = '0; eret = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        raddr = a;
        #1;
        v = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        irq = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        idle();
        mtc0 = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        mtc0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] c;
        logic        reached;

        //          mtc0  waddr        wdata          raddr        pc           exc   cause        eret  trap  rdata          depth
        vecs[0]  = '{1'b0, 5'd0,        32'h0,         REG_STATUS,  32'h100,     1'b1, EXC_SYSCALL, 1'b0, 1'b1, 32'h0000_01E0, 2'd1};
        vecs[1]  = '{1'b0, 5'd0,        32'h0,         REG_EPC,     32'h300,     1'b0, 5'd0,        1'b0, 1'b0, 32'h0000_00FC, 2'd1};
        vecs[2]  = '{1'b0, 5'd0,        32'h0,         REG_CAUSE,   32'h300,     1'b0, 5'd0,        1'b0, 1'b0, 32'h0000_0020, 2'd1};
        vecs[3]  = '{1'b1, REG_STATUS,  32'h0000_000B, REG_STATUS,  32'h304,     1'b0, 5'd0,        1'b0, 1'b0, 32'h0000_000B, 2'd1};
        vecs[4]  = '{1'b1, REG_EPC,     32'h0000_0055, REG_EPC,     32'h308,     1'b1, EXC_BREAK,   1'b0, 1'b0, 32'h0000_0055, 2'd1};
        vecs[5]  = '{1'b0, 5'd0,        32'h0,         REG_STATUS,  32'h30C,     1'b1, EXC_BREAK,   1'b0, 1'b0, 32'h0000_000B, 2'd1};
        vecs[6]  = '{1'b1, REG_STATUS,  32'hFFFF_FFFF, REG_STATUS,  32'h310,     1'b1, 5'd5,        1'b0, 1'b0, 32'hFFFF_7FFF, 2'd1};
        vecs[7]  = '{1'b1, REG_STATUS,  32'h0000_000B, REG_STATUS,  32'h314,     1'b0, 5'd0,        1'b0, 1'b0, 32'h0000_000B, 2'd1};
        vecs[8]  = '{1'b0, 5'd0,        32'h0,         REG_EPC,     32'h400,     1'b1, EXC_TEQ,     1'b0, 1'b1, 32'h0000_03FC, 2'd2};
        vecs[9]  = '{1'b1, REG_EPC,     32'h0000_0077, REG_STATUS,  32'h500,     1'b1, EXC_SYSCALL, 1'b1, 1'b0, 32'h0000_000B, 2'd1};
        vecs[10] = '{1'b0, 5'd0,        32'h0,         REG_EPC,     32'h504,     1'b0, 5'd0,        1'b0, 1'b0, 32'h0000_03FC, 2'd1};
        vecs[11] = '{1'b1, 5'd5,        32'h0000_DEAD, 5'd5,        32'h508,     1'b0, 5'd0,        1'b0, 1'b0, 32'h0000_0000, 2'd1};
        vecs[12] = '{1'b1, REG_EPC,     32'h0000_0099, REG_EPC,     32'h104,     1'b1, EXC_SYSCALL, 1'b0, 1'b1, 32'h0000_0100, 2'd2};
        vecs[13] = '{1'b0, 5'd0,        32'h0,         REG_CAUSE,   32'h108,     1'b0, 5'd0,        1'b0, 1'b0, 32'h0000_0020, 2'd2};

        push_exp   = '{32'h0000_01E0, 32'h0000_3C60, 32'h0000_0CE0, 32'h0000_1D60};
        push_depth = '{2'd1, 2'd2, 2'd3, 2'd3};
        live_w     = '{32'h0000_0003, 32'h0000_0007, 32'h0000_000B};
        pop_exp    = '{32'h0000_00EB, 32'h0000_0007, 32'h0000_0000};
        pop_depth  = '{2'd2, 2'd1, 2'd0};

        // Reset state
        pc = 32'h0000_0ABC;
        #12;
        chk("rst_status", status, 32'h0000_000F);
        chk("rst_epc", epc, 32'h0);
        chk("rst_depth", {30'd0, depth}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_trap_addr", trap_addr, 32'h0000_0ABC);
        rd(REG_CAUSE, v);
        chk("rst_cause", v, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            mtc0 = vecs[i].mtc0; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr = vecs[i].raddr; pc = vecs[i].pc; exception = vecs[i].exc;
            cause = vecs[i].cause; eret = vecs[i].eret;
            #1;
            chk($sformatf("v%0d_trap", i), {31'd0, trap}, {31'd0, vecs[i].exp_trap});
            chk($sformatf("v%0d_trap_addr", i), trap_addr, vecs[i].exp_trap ? VEC : vecs[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_depth", i), {30'd0, depth}, {30'd0, vecs[i].exp_depth});
        end

        // External interrupt: latency through the synchroniser
        do_reset();
        write_reg(REG_STATUS, 32'h0001_001F);
        @(negedge clk);
        idle();
        pc = 32'h200;
        irq = 6'b000001;
        #1;
        chk("irq_lat0", {31'd0, trap}, 32'd0);
        for (int k = 1; k <= SYNC; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("irq_lat%0d", k), {31'd0, trap}, (k == SYNC) ? 32'd1 : 32'd0);
            if (k == SYNC) chk("irq_trap_addr", trap_addr, VEC);
        end
        @(posedge clk);
        #1;
        chk("irq_epc", epc, 32'h200);
        chk("irq_status", status, 32'h0001_03E0);
        chk("irq_depth", {30'd0, depth}, 32'd1);
        chk("irq_no_retrap", {31'd0, trap}, 32'd0);
        rd(REG_CAUSE, v);
        chk("irq_cause_held", v, 32'h0001_0000);
        @(negedge clk);
        irq = '0;
        repeat (SYNC) @(posedge clk);
        #1;
        rd(REG_CAUSE, v);
        chk("irq_cause_drop", v, 32'h0);

        // Timer: Count/Compare sticky flag
        do_reset();
        write_reg(REG_COUNT, 32'h0);
        rd(REG_COUNT, v);
        chk("count_write", v, 32'h0);
        write_reg(REG_COMPARE, 32'd5);
        @(negedge clk);
        idle();
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            @(posedge clk);
            #1;
            rd(REG_COUNT, c);
            rd(REG_CAUSE, v);
            if (c <= 32'd4) chk($sformatf("timer_clear_c%0d", c), {31'd0, v[TIMER_BIT]}, 32'd0);
            else if (c >= 32'd7) chk($sformatf("timer_set_c%0d", c), {31'd0, v[TIMER_BIT]}, 32'd1);
            if (c >= 32'd12) reached = 1'b1;
        end
        chk("timer_reached", {31'd0, reached}, 32'd1);
        write_reg(REG_COMPARE, 32'd20);
        rd(REG_CAUSE, v);
        chk("timer_cleared", {31'd0, v[TIMER_BIT]}, 32'd0);
        @(posedge clk);
        #1;
        rd(REG_CAUSE, v);
        chk("timer_stays_clear", {31'd0, v[TIMER_BIT]}, 32'd0);

        // Nesting: four syscalls, depth saturates, then unwind
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            exception = 1'b1; cause = EXC_SYSCALL; pc = 32'h1000 + 32'(i * 16);
            #1;
            chk($sformatf("nest%0d_trap", i), {31'd0, trap}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("nest%0d_status", i), status, push_exp[i]);
            chk($sformatf("nest%0d_depth", i), {30'd0, depth}, {30'd0, push_depth[i]});
            chk($sformatf("nest%0d_epc", i), epc, 32'h0FFC + 32'(i * 16));
            if (i < 3) begin
                write_reg(REG_STATUS, push_exp[i] | live_w[i]);
                chk($sformatf("nest%0d_live", i), status, push_exp[i] | live_w[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            eret = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("eret%0d_status", i), status, pop_exp[i]);
            chk($sformatf("eret%0d_depth", i), {30'd0, depth}, {30'd0, pop_depth[i]});
        end
        write_reg(REG_STATUS, 32'h0000_01E3);
        @(negedge clk);
        idle();
        eret = 1'b1;
        @(posedge clk);
        #1;
        chk("eret3_noop_status", status, 32'h0000_01E3);
        chk("eret3_noop_depth", {30'd0, depth}, 32'd0);

        // Async reset in the middle of a trap cycle
        do_reset();
        write_reg(REG_STATUS, 32'h0001_000F);
        write_reg(REG_EPC, 32'h0000_1234);
        @(negedge clk);
        idle();
        exception = 1'b1; cause = EXC_SYSCALL; pc = 32'h0000_0800;
        #1;
        chk("arst_pre_trap", {31'd0, trap}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_trap", {31'd0, trap}, 32'd0);
        chk("arst_trap_addr", trap_addr, 32'h0000_0800);
        chk("arst_status", status, 32'h0000_000F);
        chk("arst_epc", epc, 32'h0);
        chk("arst_depth", {30'd0, depth}, 32'd0);
        rd(REG_COUNT, v);
        chk("arst_count", v, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
